// File: rtl/pq_cmd_sched.sv
// Command scheduler in front of a HWPQ core: buffers inserts, counts dequeues, issues one command per cycle.
// Latency: insert issued the cycle after accept, dequeue result registered one cycle after issue.
// Backpressure: enq_ready/deq_ready drop when the FIFO or pending count is full; out stream holds until out_ready.

package pq_pkg;
    parameter int KEY_W = 8;
    parameter int VAL_W = 8;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [VAL_W-1:0] value;
    } kv_t;

    localparam kv_t KV_EMPTY = '{key: {KEY_W{1'b1}}, value: {VAL_W{1'b0}}};
endpackage

// Show-ahead circular FIFO; the extra pointer bit tells full from empty.
module pq_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end
endmodule

module pq_cmd_sched
    import pq_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int DEQ_PEND_MAX = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic enq_valid,
    input  kv_t  enq_kv,
    output logic enq_ready,
    input  logic deq_valid,
    output logic deq_ready,
    output logic out_valid,
    output kv_t  out_kv,
    input  logic out_ready,
    output logic pq_enq,
    output logic pq_deq,
    output kv_t  pq_kvi,
    input  kv_t  pq_kvo,
    input  logic pq_full,
    input  logic pq_empty,
    input  logic pq_busy
);
    localparam int PEND_W = $clog2(DEQ_PEND_MAX + 1);

    typedef enum logic {RR_ENQ = 1'b0, RR_DEQ = 1'b1} rr_t;

    rr_t               rr_last;
    logic [PEND_W-1:0] pend_cnt;
    logic              fifo_empty;
    logic              fifo_full;
    logic [$bits(kv_t)-1:0] fifo_head;
    logic              enq_acc;
    logic              deq_acc;
    logic              out_slot_free;
    logic              can_enq;
    logic              can_deq;

    pq_fifo #(
        .W     ($bits(kv_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (enq_acc),
        .push_dat (enq_kv),
        .pop      (pq_enq),
        .head     (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign enq_ready = !fifo_full;
    assign deq_ready = (pend_cnt < PEND_W'(DEQ_PEND_MAX));
    assign enq_acc   = enq_valid && enq_ready;
    assign deq_acc   = deq_valid && deq_ready;

    assign out_slot_free = !out_valid || out_ready;
    assign can_enq = !fifo_empty && !pq_full && !pq_busy;
    assign can_deq = (pend_cnt != '0) && !pq_empty && !pq_busy && out_slot_free;

    // When both are eligible, the side that did not issue last wins.
    assign pq_enq = can_enq && (!can_deq || rr_last == RR_DEQ);
    assign pq_deq = can_deq && !pq_enq;
    assign pq_kvi = pq_enq ? kv_t'(fifo_head) : KV_EMPTY;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last   <= RR_DEQ;
            pend_cnt  <= '0;
            out_valid <= 1'b0;
            out_kv    <= KV_EMPTY;
        end else begin
            if (pq_enq) begin
                rr_last <= RR_ENQ;
            end else if (pq_deq) begin
                rr_last <= RR_DEQ;
            end

            if (deq_acc && !pq_deq) begin
                pend_cnt <= pend_cnt + PEND_W'(1);
            end else if (pq_deq && !deq_acc) begin
                pend_cnt <= pend_cnt - PEND_W'(1);
            end

            // A fresh capture overrides the clear so back-to-back results have no bubble.
            if (pq_deq) begin
                out_valid <= 1'b1;
                out_kv    <= pq_kvo;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
